// File: rtl/johnson_phase_monitor.sv
// Validates and decodes a 4-bit Johnson counter code into phase/one-hot, tracks sequence lock and revolutions.
// Optional saturating error counter enabled by defining JPM_ERR_CNT_EN.
module johnson_phase_monitor #(
  parameter int LOCK_LEN = 4,
  parameter int REV_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [3:0]       jc_in,
  output logic [2:0]       phase,
  output logic [7:0]       phase_oh,
  output logic             valid,
  output logic             locked,
  output logic             rev_pulse,
  output logic [REV_W-1:0] rev_count,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {UNLOCK, ACQ, LOCK} state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_LEN);

  state_t     state, state_nxt;
  logic [3:0] good_cnt, good_nxt;
  logic [3:0] prev_code;
  logic       have_prev;

  logic       legal, hold, adv, skip, seq_err, rev_hit;
  logic [2:0] cur_ph, prev_ph;
  logic [3:0] good_inc;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] dec_phase(input logic [3:0] c);
    case (c)
      4'b1000: dec_phase = 3'd1;
      4'b1100: dec_phase = 3'd2;
      4'b1110: dec_phase = 3'd3;
      4'b1111: dec_phase = 3'd4;
      4'b0111: dec_phase = 3'd5;
      4'b0011: dec_phase = 3'd6;
      4'b0001: dec_phase = 3'd7;
      default: dec_phase = 3'd0;
    endcase
  endfunction

  // Sequence classes are only meaningful against a legal previous sample.
  always_comb begin
    legal    = is_legal(jc_in);
    cur_ph   = dec_phase(jc_in);
    prev_ph  = dec_phase(prev_code);
    hold     = legal && have_prev && (jc_in == prev_code);
    adv      = legal && have_prev && !hold && (cur_ph == prev_ph + 3'd1);
    skip     = legal && have_prev && !hold && !adv;
    good_inc = good_cnt + 4'd1;
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    seq_err   = 1'b0;
    case (state)
      UNLOCK: begin
        if (legal) begin
          state_nxt = ACQ;
          good_nxt  = 4'd0;
        end
      end
      ACQ: begin
        if (!legal) begin
          state_nxt = UNLOCK;
        end else if (adv) begin
          good_nxt = good_inc;
          if (good_inc == LOCK_CNT) state_nxt = LOCK;
        end else if (skip) begin
          seq_err  = 1'b1;
          good_nxt = 4'd0;
        end
      end
      LOCK: begin
        if (!legal) begin
          state_nxt = UNLOCK;
        end else if (skip) begin
          seq_err   = 1'b1;
          state_nxt = ACQ;
          good_nxt  = 4'd0;
        end
      end
      default: begin
        state_nxt = UNLOCK;
        good_nxt  = 4'd0;
      end
    endcase
  end

  // A LOCK-entering advance happens in ACQ, so it never counts as a revolution.
  assign rev_hit = (state == LOCK) && adv && (prev_ph == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNLOCK;
      good_cnt  <= 4'd0;
      prev_code <= 4'd0;
      have_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      have_prev <= legal;
      if (legal) prev_code <= jc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= 3'd0;
      phase_oh    <= 8'd0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      rev_pulse   <= 1'b0;
      rev_count   <= '0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      valid       <= legal;
      locked      <= (state_nxt == LOCK);
      rev_pulse   <= rev_hit;
      err_illegal <= !legal;
      err_seq     <= seq_err;
      if (legal) begin
        phase    <= cur_ph;
        phase_oh <= 8'(1) << cur_ph;
      end else begin
        phase_oh <= 8'd0;
      end
      if (clr)          rev_count <= '0;
      else if (rev_hit) rev_count <= rev_count + REV_W'(1);
    end
  end

`ifdef JPM_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt_q <= 8'd0;
    else if (clr)
      err_cnt_q <= 8'd0;
    else if ((!legal || seq_err) && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
